// File: rtl/spi_cfg_sequencer.sv
// Purpose: arbitrates two register-write requesters and serialises each write as a 16-bit SPI mode-0 frame.
// Latency: frame starts the cycle after acceptance; cs_n low 33*CLK_DIV cycles, then GAP_CYCLES idle.
// Backpressure: readyN only in IDLE, one round-robin grant at a time; optional SPI_SEQ_DEDUP_EN skips rewrites.
module spi_cfg_sequencer #(
    parameter int         CLK_DIV     = 4,
    parameter int         GAP_CYCLES  = 4,
    parameter logic [6:0] MAX_ADDRESS = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rr_ptr;       // 1: requester 1 has priority
    logic        grant0, grant1, accept, in_range, dup, launch;
    logic [6:0]  sel_addr;
    logic [7:0]  sel_data;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic        phase_hi;
    logic [15:0] shreg;

    // Round-robin grant and handshake; ready is only offered while idle and out of reset
    always_comb begin
        grant0     = req0_valid && (!rr_ptr || !req1_valid);
        grant1     = req1_valid && (rr_ptr || !req0_valid);
        req0_ready = (state_q == IDLE) && !rst && grant0;
        req1_ready = (state_q == IDLE) && !rst && grant1;
        accept     = req0_ready || req1_ready;
        sel_addr   = grant1 ? req1_addr : req0_addr;
        sel_data   = grant1 ? req1_data : req0_data;
        in_range   = sel_addr <= MAX_ADDRESS;
        launch     = accept && in_range && !dup;
    end

`ifdef SPI_SEQ_DEDUP_EN
    logic [7:0]           shadow_dat [0:MAX_ADDRESS];
    logic [MAX_ADDRESS:0] shadow_vld;

    // A write is redundant when the last data sent to that address matches
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i <= int'(MAX_ADDRESS); i++) begin
            if (sel_addr == 7'(i) && shadow_vld[i] && shadow_dat[i] == sel_data) begin
                dup = 1'b1;
            end
        end
    end

    // Shadow valid bits: cleared by reset, set by every launched frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_vld <= '0;
        end else if (launch) begin
            for (int i = 0; i <= int'(MAX_ADDRESS); i++) begin
                if (sel_addr == 7'(i)) shadow_vld[i] <= 1'b1;
            end
        end
    end

    // Shadow data follows every launched frame; contents are meaningless until valid
    always_ff @(posedge clk) begin
        if (launch) begin
            for (int i = 0; i <= int'(MAX_ADDRESS); i++) begin
                if (sel_addr == 7'(i)) shadow_dat[i] <= sel_data;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Requester granted last drops to lower priority; err flags an out-of-range acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (accept) rr_ptr <= grant0;
            err <= accept && !in_range;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and SPI pins; pins decode straight from state so reset lifts cs_n without a clock
    always_comb begin
        state_d = state_q;
        sclk    = 1'b0;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        busy    = state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (launch) state_d = SETUP;
            end
            SETUP: begin
                cs_n = 1'b0;
                mosi = shreg[15];
                if (div_cnt == DIV_LAST) state_d = SHIFT;
            end
            SHIFT: begin
                cs_n = 1'b0;
                mosi = shreg[15];
                sclk = phase_hi;
                if (div_cnt == DIV_LAST && !phase_hi && bit_cnt == 5'd15) state_d = GAP;
            end
            GAP: begin
                if (div_cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider, bit counter and shift register; data shifts on each sclk fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            shreg    <= '0;
        end else if (launch) begin
            shreg    <= {1'b1, sel_addr, sel_data};
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b1;
        end else if (state_q != state_d) begin
            div_cnt <= '0;
        end else if (state_q == SHIFT && div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            phase_hi <= !phase_hi;
            if (phase_hi) shreg   <= {shreg[14:0], 1'b0};
            else          bit_cnt <= bit_cnt + 5'd1;
        end else if (state_q != IDLE) begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Purpose: random and directed writes against a frame-level model of the SPI write sequencer.
// Latency: each step waits for the bus to return idle before comparing frames, timings and err pulses.
// Backpressure: requester drivers hold valid/addr/data until ready, bounded by a cycle budget.
module tb_spi_cfg_sequencer;

    localparam int         CLK_DIV    = 4;
    localparam int         GAP_CYCLES = 4;
    localparam logic [6:0] MAX_ADDR   = 7'h04;
    localparam int         CS_LOW     = 33 * CLK_DIV;
    localparam int         BUSY_LEN   = CS_LOW + GAP_CYCLES;
`ifdef SPI_SEQ_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [6:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       sclk, mosi, cs_n, busy, err;

    int vectors     = 0;
    int miscompares = 0;

    // Observed bus activity
    logic [15:0] obs_frames[$];
    int          cs_runs[$];
    int          busy_runs[$];
    int          err_seen = 0;

    // Reference model state
    int          ptr = 0;
    bit          sv[0:127];
    logic [7:0]  sd[0:127];
    logic [15:0] exp_frames[$];
    int          exp_err = 0;

    spi_cfg_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .MAX_ADDRESS(MAX_ADDR)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: rebuilds frames from sclk rises, measures cs_n-low and busy runs, counts err cycles
    initial begin
        logic [15:0] sh;
        int nb, cs_run, busy_run;
        logic p_sclk, p_cs, p_mosi;
        sh = '0; nb = 0; cs_run = 0; busy_run = 0; p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sh = '0; nb = 0; cs_run = 0; busy_run = 0;
                p_sclk = 1'b0; p_cs = 1'b1; p_mosi = 1'b0;
            end else begin
                if (err) err_seen++;
                if (busy) busy_run++;
                else if (busy_run > 0) begin
                    busy_runs.push_back(busy_run);
                    busy_run = 0;
                end
                if (!cs_n) begin
                    cs_run++;
                    if (sclk && !p_sclk) begin
                        sh = {sh[14:0], mosi};
                        nb++;
                    end
                    if (!p_cs && mosi !== p_mosi) check("mosi_on_fall", 32'(p_sclk && !sclk), 32'd1);
                end else if (!p_cs) begin
                    check("bits_per_frame", nb, 16);
                    check("idle_lines", {30'd0, sclk, mosi}, 32'd0);
                    obs_frames.push_back(sh);
                    cs_runs.push_back(cs_run);
                    cs_run = 0;
                    nb = 0;
                end
                p_sclk = sclk; p_cs = cs_n; p_mosi = mosi;
            end
        end
    end

    // Model of one accepted request
    task automatic model(input int id, input logic [6:0] a, input logic [7:0] d);
        if (a > MAX_ADDR) exp_err++;
        else if (!(DEDUP && sv[a] && sd[a] == d)) begin
            exp_frames.push_back({1'b1, a, d});
            sv[a] = 1'b1;
            sd[a] = d;
        end
        ptr = 1 - id;
    endtask

    task automatic model_reset();
        ptr = 0;
        for (int i = 0; i < 128; i++) sv[i] = 1'b0;
        exp_frames.delete();
        exp_err = 0;
    endtask

    // Hold a request until ready; t is the acceptance time (0 if the budget ran out)
    task automatic drive(input int r, input logic [6:0] a, input logic [7:0] d, output time t);
        t = 0;
        if (r == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
        for (int k = 0; k < 600; k++) begin
            #1;
            if (((r == 0) ? req0_ready : req1_ready) === 1'b1) begin
                @(posedge clk);
                t = $time;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 1000 && !done; k++) begin
            #1;
            if (!busy && cs_n) done = 1'b1;
            else @(negedge clk);
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic compare_step();
        check("frame_count", obs_frames.size(), exp_frames.size());
        check("cs_run_count", cs_runs.size(), exp_frames.size());
        check("busy_run_count", busy_runs.size(), exp_frames.size());
        while (obs_frames.size() > 0 && exp_frames.size() > 0)
            check("frame", 32'(obs_frames.pop_front()), 32'(exp_frames.pop_front()));
        foreach (cs_runs[i])   check("cs_low_cycles", cs_runs[i], CS_LOW);
        foreach (busy_runs[i]) check("busy_cycles", busy_runs[i], BUSY_LEN);
        check("err_pulses", err_seen, exp_err);
        obs_frames.delete(); exp_frames.delete(); cs_runs.delete(); busy_runs.delete();
        err_seen = 0; exp_err = 0;
    endtask

    task automatic run_step(input bit v0, input bit v1, input logic [6:0] a0, input logic [7:0] d0,
                            input logic [6:0] a1, input logic [7:0] d1);
        time t0, t1;
        int  first;
        t0 = 0; t1 = 0;
        first = (v0 && v1) ? ptr : (v0 ? 0 : 1);
        if (first == 0) begin
            if (v0) model(0, a0, d0);
            if (v1) model(1, a1, d1);
        end else begin
            if (v1) model(1, a1, d1);
            if (v0) model(0, a0, d0);
        end
        fork
            begin if (v0) drive(0, a0, d0, t0); end
            begin if (v1) drive(1, a1, d1, t1); end
        join
        if (v0) check("accepted0", 32'(t0 != 0), 32'd1);
        if (v1) check("accepted1", 32'(t1 != 0), 32'd1);
        if (v0 && v1) check("grant_order", 32'(t1 < t0), first);
        wait_idle();
        compare_step();
    endtask

    initial begin
        time t;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset 40 cycles into a frame abandons it
        drive(0, 7'h03, 8'h5A, t);
        check("abort_accepted", 32'(t != 0), 32'd1);
        repeat (39) @(negedge clk);
        #1;
        check("midframe_cs_n", 32'(cs_n), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("aborted_frames", obs_frames.size(), 0);
        obs_frames.delete(); cs_runs.delete(); busy_runs.delete(); err_seen = 0;
        run_step(1, 0, 7'h03, 8'h5A, 7'h00, 8'h00);

        // Single write, out-of-range write, two simultaneous pairs, repeated write
        run_step(1, 0, 7'h02, 8'hA5, 7'h00, 8'h00);
        run_step(0, 1, 7'h00, 8'h00, 7'h05, 8'h77);
        run_step(1, 1, 7'h00, 8'h11, 7'h01, 8'h22);
        run_step(1, 1, 7'h00, 8'h33, 7'h01, 8'h44);
        run_step(1, 0, 7'h04, 8'h80, 7'h00, 8'h00);
        run_step(1, 0, 7'h04, 8'h80, 7'h00, 8'h00);

        // Random traffic, narrow data set so repeats happen
        for (int n = 0; n < 40; n++) begin
            int         pat;
            logic [6:0] a0, a1;
            logic [7:0] d0, d1;
            pat = $urandom_range(1, 3);
            a0 = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            a1 = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            d0 = 8'($urandom_range(0, 3) * 85);
            d1 = 8'($urandom_range(0, 3) * 85);
            run_step(pat[0], pat[1], a0, d0, a1, d1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares %0d", miscompares);
        $fatal(1, "watchdog");
    end

endmodule
